// File: rtl/fir_pkg.sv
// Shared widths, default tap set and accumulator sizing for the folded FIR filter.
package fir_pkg;

    localparam int DW      = 16;
    localparam int PW      = 2 * DW;
    localparam int TAP_DEF = 8;
    localparam int CPS_DEF = 2;

    typedef logic signed [DW-1:0] coef_t;
    typedef coef_t coef_arr_t [TAP_DEF];

    localparam coef_arr_t COEF_DEF = '{
        16'sd1, 16'sd2, 16'sd3, 16'sd4, 16'sd4, 16'sd3, 16'sd2, 16'sd1
    };

    // Full-precision products plus headroom for summing every tap.
    function automatic int acc_width(input int taps);
        return PW + $clog2(taps);
    endfunction

endpackage

// File: rtl/fir_mac_slice.sv
// Multiply-accumulate for one tap group: M full-precision products summed
// into an accumulator-width partial sum.
module fir_mac_slice
    import fir_pkg::*;
#(
    parameter int M    = 4,
    parameter int ACCW = 35
) (
    input  logic signed [DW-1:0]   x_grp_i    [M],
    input  coef_t                  coef_grp_i [M],
    output logic signed [ACCW-1:0] psum_o
);

    logic signed [PW-1:0] prod [M];

    always_comb begin
        psum_o = '0;
        for (int j = 0; j < M; j++) begin
            prod[j] = x_grp_i[j] * coef_grp_i[j];
            psum_o  = psum_o + ACCW'(prod[j]);
        end
    end

endmodule

// File: rtl/top_generic_fir_filter.sv
// Time-folded FIR: TAP taps evaluated over CPS cycles, M = TAP/CPS taps per cycle.
// Define FIR_SAT_EN to saturate the output; the default build wraps to 16 bits.
module top_generic_fir_filter
    import fir_pkg::*;
#(
    parameter int    TAP        = TAP_DEF,
    parameter int    CPS        = CPS_DEF,
    parameter coef_t COEF [TAP] = COEF_DEF,
    parameter int    SHIFT      = 0
) (
    input  logic                 clk_data,
    input  logic                 rst,
    input  logic signed [DW-1:0] in_data,
    output logic signed [DW-1:0] out_data,
    output logic                 out_valid
);

    localparam int M    = (CPS >= 1) ? TAP / CPS : 1;
    localparam int ACCW = acc_width(TAP);
    localparam int PHW  = (CPS > 1) ? $clog2(CPS) : 1;
    localparam logic [PHW-1:0] PH_LAST = PHW'(CPS - 1);
    localparam logic signed [ACCW-1:0] SAT_MAX = ACCW'(32767);
    localparam logic signed [ACCW-1:0] SAT_MIN = ACCW'(-32768);

    if (CPS < 1) begin : g_bad_cps
        $error("top_generic_fir_filter: CPS must be >= 1");
    end else if ((TAP % CPS) != 0) begin : g_bad_tap
        $error("top_generic_fir_filter: TAP must be a multiple of CPS");
    end

    logic [PHW-1:0]         ph_q, ph_d;
    logic signed [DW-1:0]   x_q [TAP];
    logic signed [DW-1:0]   x_d [TAP];
    logic signed [ACCW-1:0] acc_q, acc_d;
    logic signed [DW-1:0]   out_q, out_d;
    logic                   valid_q, valid_d;

    logic                   last_ph;
    logic signed [DW-1:0]   x_grp [M];
    coef_t                  c_grp [M];
    logic signed [ACCW-1:0] psum;
    logic signed [ACCW-1:0] acc_sum;
    logic signed [ACCW-1:0] acc_shr;
    logic signed [DW-1:0]   y_fmt;

    // Tap group p covers h[p*M .. p*M+M-1] and is evaluated while ph == p.
    always_comb begin
        for (int j = 0; j < M; j++) begin
            x_grp[j] = x_q[j];
            c_grp[j] = COEF[j];
        end
        for (int p = 1; p < CPS; p++) begin
            if (ph_q == PHW'(p)) begin
                for (int j = 0; j < M; j++) begin
                    x_grp[j] = x_q[p*M + j];
                    c_grp[j] = COEF[p*M + j];
                end
            end
        end
    end

    fir_mac_slice #(
        .M    (M),
        .ACCW (ACCW)
    ) u_mac (
        .x_grp_i    (x_grp),
        .coef_grp_i (c_grp),
        .psum_o     (psum)
    );

    always_comb begin
        acc_sum = acc_q + psum;
        acc_shr = acc_sum >>> SHIFT;
`ifdef FIR_SAT_EN
        if (acc_shr > SAT_MAX) begin
            y_fmt = 16'sh7fff;
        end else if (acc_shr < SAT_MIN) begin
            y_fmt = -16'sh8000;
        end else begin
            y_fmt = DW'(acc_shr);
        end
`else
        y_fmt = DW'(acc_shr);
`endif
    end

    // The last phase both finishes the current output and shifts in the next
    // sample; the MAC still sees the pre-shift delay line on that edge.
    always_comb begin
        last_ph = (ph_q == PH_LAST);
        ph_d    = last_ph ? '0 : ph_q + PHW'(1);
        x_d     = x_q;
        acc_d   = acc_sum;
        out_d   = out_q;
        valid_d = last_ph;
        if (last_ph) begin
            x_d[0] = in_data;
            for (int k = 1; k < TAP; k++) begin
                x_d[k] = x_q[k-1];
            end
            acc_d = '0;
            out_d = y_fmt;
        end
    end

    always_ff @(posedge clk_data) begin
        if (rst) begin
            ph_q    <= '0;
            acc_q   <= '0;
            out_q   <= '0;
            valid_q <= 1'b0;
            for (int k = 0; k < TAP; k++) begin
                x_q[k] <= '0;
            end
        end else begin
            ph_q    <= ph_d;
            acc_q   <= acc_d;
            out_q   <= out_d;
            valid_q <= valid_d;
            x_q     <= x_d;
        end
    end

    assign out_data  = out_q;
    assign out_valid = valid_q;

`ifndef FIR_SAT_EN
    logic unused_sat_limits;
    assign unused_sat_limits = ^{SAT_MAX, SAT_MIN};
`endif

endmodule

// File: tb/tb_top_generic_fir_filter.sv
// Directed bench for the folded FIR: three instances (CPS = 1, 2, 4) with the default taps.
module tb_top_generic_fir_filter;

    logic clk = 1'b0;
    logic rst;
    logic signed [15:0] in1, in2, in4;
    logic signed [15:0] d1, d2, d4;
    logic v1, v2, v4;

    int n_cmp = 0;
    int n_bad = 0;
    int q1[$];
    int q2[$];
    int q4[$];
    int e_imp[$];
    int e_imp1[$];
    int e_stp[$];
    int e_neg[$];
    int sat_hi;
    int sat_lo;

    always #5 clk = ~clk;

    top_generic_fir_filter #(.TAP(8), .CPS(1)) u_dut1 (
        .clk_data (clk), .rst (rst), .in_data (in1), .out_data (d1), .out_valid (v1)
    );
    top_generic_fir_filter #(.TAP(8), .CPS(2)) u_dut2 (
        .clk_data (clk), .rst (rst), .in_data (in2), .out_data (d2), .out_valid (v2)
    );
    top_generic_fir_filter #(.TAP(8), .CPS(4)) u_dut4 (
        .clk_data (clk), .rst (rst), .in_data (in4), .out_data (d4), .out_valid (v4)
    );

    always @(posedge clk) begin
        #1;
        if (v1) q1.push_back(int'(d1));
        if (v2) q2.push_back(int'(d2));
        if (v4) q4.push_back(int'(d4));
    end

    task automatic chk(input string tag, input int obs, input int exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
        end
    endtask

    task automatic chk_q(input string tag, input int q[$], input int e[$]);
        for (int i = 0; i < e.size(); i++) begin
            chk($sformatf("%s[%0d]", tag, i), (i < q.size()) ? q[i] : -999999, e[i]);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic do_reset();
        rst = 1'b1;
        step();
        step();
        chk("rst_d1", d1, 0);
        chk("rst_v1", v1, 0);
        chk("rst_d2", d2, 0);
        chk("rst_v2", v2, 0);
        chk("rst_d4", d4, 0);
        chk("rst_v4", v4, 0);
        rst = 1'b0;
        q1.delete();
        q2.delete();
        q4.delete();
    endtask

    function automatic int last_of(input int q[$]);
        return (q.size() > 0) ? q[q.size()-1] : -999999;
    endfunction

    initial begin
        // Leading 0: the first strobe after reset reflects the cleared delay line.
        e_imp  = '{0, 1, 2, 3, 4, 4, 3, 2, 1, 0, 0};
        e_imp1 = '{0, 1, 2, 3, 4, 4, 3, 2, 1};
        e_stp  = '{0, 1, 3, 6, 10, 14, 17, 19, 20, 20};
        e_neg  = '{0, -1, -3, -6, -10, -14, -17, -19, -20, -20};
`ifdef FIR_SAT_EN
        sat_hi = 32767;
        sat_lo = -32768;
`else
        sat_hi = -20;
        sat_lo = 0;
`endif
        rst = 1'b1;
        in1 = '0;
        in2 = '0;
        in4 = '0;

        // Impulse, each input held for exactly one sample period.
        do_reset();
        in1 = 16'sd1;
        in2 = 16'sd1;
        in4 = 16'sd1;
        for (int c = 1; c <= 48; c++) begin
            step();
            if (c <= 4) begin
                chk($sformatf("strobe1_c%0d", c), int'(v1), 1);
                chk($sformatf("strobe2_c%0d", c), int'(v2), (c % 2 == 0) ? 1 : 0);
                chk($sformatf("strobe4_c%0d", c), int'(v4), (c % 4 == 0) ? 1 : 0);
            end
            if (c == 3) chk("lat2_hold", d2, 0);
            if (c == 4) chk("lat2_first", d2, 1);
            in1 = '0;
            in2 = (c < 2) ? 16'sd1 : 16'sd0;
            in4 = (c < 4) ? 16'sd1 : 16'sd0;
        end
        chk_q("imp1", q1, e_imp1);
        chk_q("imp2", q2, e_imp);
        chk_q("imp4", q4, e_imp);

        // Positive step interrupted by reset while ph == 1.
        do_reset();
        in1 = 16'sd1;
        in2 = 16'sd1;
        in4 = 16'sd1;
        run(7);
        chk("step2_pre_rst", d2, 3);
        rst = 1'b1;
        step();
        chk("midrst_d2", d2, 0);
        chk("midrst_v2", v2, 0);
        rst = 1'b0;
        q1.delete();
        q2.delete();
        q4.delete();
        run(20);
        chk_q("step1", q1, e_stp);
        chk_q("step2", q2, e_stp);

        // Negative step.
        do_reset();
        in1 = -16'sd1;
        in2 = -16'sd1;
        in4 = -16'sd1;
        run(40);
        chk_q("neg2", q2, e_neg);
        chk_q("neg4", q4, e_neg);

        // Full-scale positive and negative steps (steady sums 655340 / -655360).
        do_reset();
        in1 = 16'sd32767;
        in2 = 16'sd32767;
        in4 = 16'sd32767;
        run(40);
        chk("ovf_hi1", last_of(q1), sat_hi);
        chk("ovf_hi2", last_of(q2), sat_hi);
        chk("ovf_hi4", last_of(q4), sat_hi);

        do_reset();
        in1 = -16'sd32768;
        in2 = -16'sd32768;
        in4 = -16'sd32768;
        run(40);
        chk("ovf_lo1", last_of(q1), sat_lo);
        chk("ovf_lo2", last_of(q2), sat_lo);
        chk("ovf_lo4", last_of(q4), sat_lo);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/top_generic_fir_filter.md
TOP_GENERIC_FIR_FILTER -- requirements
Module: top_generic_fir_filter

Interface
REQ-001 Parameter TAP, default 8, number of filter taps; SHALL be a multiple of CPS.
REQ-002 Parameter CPS, default 2, clock cycles per sample (fold factor), CPS >= 1.
REQ-003 Parameter COEF, default {1,2,3,4,4,3,2,1} (h[0]..h[7]), signed 16-bit tap coefficients.
REQ-004 Parameter SHIFT, default 0, arithmetic right shift applied to the accumulator before output.
REQ-005 clk_data  input  1  sole clock; all logic on its rising edge.
REQ-006 rst  input  1  reset; one clock; reset is synchronous and active-high.
REQ-007 in_data  input  16  signed two's-complement sample, sampled once per CPS cycles.
REQ-008 out_data  output  16  signed filtered sample, registered.
REQ-009 out_valid  output  1  one-cycle pulse when out_data updates.

Function
REQ-010 Phase counter ph SHALL count 0..CPS-1 and wrap, advancing every cycle outside reset.
REQ-011 On an edge with ph==CPS-1, the delay line SHALL shift: x[0]<=in_data, x[k]<=x[k-1]; in_data is ignored at other phases.
REQ-012 Define M = TAP/CPS; on an edge with ph==p, the partial sum of h[k]*x[k] for k = p*M .. p*M+M-1 SHALL be formed from the registered delay line.
REQ-013 At ph<CPS-1 the partial sum SHALL be added into accumulator acc; at ph==CPS-1, out_data SHALL load f(acc + partial), acc SHALL clear, and out_valid SHALL be 1 for that cycle.
REQ-014 y[n] = sum over k=0..TAP-1 of h[k]*x[n-k]; the output for a sample captured at edge E SHALL appear at edge E+CPS (latency CPS cycles).
REQ-015 Products SHALL be full 32-bit signed; acc width SHALL be 32+ceil(log2(TAP)) bits, with no internal overflow.
REQ-016 f() SHALL be acc >>> SHIFT, then reduced to 16 bits per REQ-020/021.
REQ-017 CPS==1 SHALL degenerate to a fully parallel filter: sample every cycle, out_valid constantly 1, latency 1 cycle.

Reset
REQ-018 While rst==1 at an edge: ph=0, acc=0, all x[k]=0, out_data=0, out_valid=0.
REQ-019 Reset asserted mid-computation SHALL discard the partial result; the first sample after release is taken at the first edge where ph==CPS-1.

Configuration
REQ-020 With macro FIR_SAT_EN defined, f() SHALL saturate to [-32768, 32767].
REQ-021 Without FIR_SAT_EN, f() SHALL wrap (keep the low 16 bits); this is the default build.

Structure
REQ-022 Package fir_pkg SHALL hold DW=16, default TAP/CPS, default COEF array type and value, and an accumulator-width function.
REQ-023 One sub-module fir_mac_slice SHALL compute the M-product partial sum for a selected tap group; the top instantiates it once.
REQ-024 Elaboration SHALL fail if TAP%CPS != 0 or CPS < 1.

Verification
REQ-025 Impulse, defaults: after reset, in_data=1 for one sample, then 0 -> out_data per out_valid: 1,2,3,4,4,3,2,1,0,0.
REQ-026 Step: in_data=1 held -> 1,3,6,10,14,17,19,20,20...; in_data=-1 held -> -1,-3,...,-20.
REQ-027 Latency/strobe, CPS=2: out_valid toggles 0,1,0,1 after reset; each output appears 2 cycles after its sample edge.
REQ-028 Overflow: in_data=32767 held, steady sum 655340 -> 32767 with FIR_SAT_EN; 655340 mod 65536 = 65516 (signed -20) without it.
REQ-029 Reset mid-run: rst pulsed during a step at ph=1 -> out_data=0 and out_valid=0 next cycle; the step response restarts at 1.
REQ-030 CPS=1, TAP=8: impulse -> 1,2,3,4,4,3,2,1 on consecutive cycles; CPS=4 gives identical values every 4th cycle.
